l1_miss_ctrl: RTL
=================

// Module: l1_miss_ctrl
// PURPOSE
//  Miss/refill sequencer for one L1 cache; sits beside the tag/valid arrays and the LRU tracker.
//  Takes an analyze-stage miss and the chosen victim way, then stalls the core.
//  Sequence per miss: invalidate the victim (write-through, no writeback), fetch the line over the
//  memory bus, write the fill into tag/data arrays, and pulse replay to restart the request.
//  Also runs a full-cache flush sweep on request.
// PARAMETERS
//  ADDR_W       32    physical address width
//  IDX_W        7     set index width (2**IDX_W sets)
//  OFF_W        4     line offset width; TAG_W = ADDR_W-IDX_W-OFF_W (localparam)
//  WAY_NUM      4     associativity; way vectors are one-hot
//  LINE_W       128   refill line width
//  TIMEOUT_CYC  255   WAIT-state cycles before the request is reissued (8-bit counter)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  arr_ready      in   1        tag/LRU arrays finished hardware clean
//  miss_val       in   1        analyze-stage miss (req & ~hit)
//  miss_addr      in   ADDR_W   miss address
//  evict_val      in   1        victim way holds valid line
//  victim_way     in   WAY_NUM  one-hot way chosen by LRU
//  flush_req      in   1        request full invalidate (level; sampled in IDLE)
//  stall          out  1        hold core pipeline
//  inv_en         out  1        clear valid bits at inv_idx/inv_way
//  inv_idx        out  IDX_W    invalidate set
//  inv_way        out  WAY_NUM  ways to clear
//  mem_req_val    out  1        line read request
//  mem_req_addr   out  ADDR_W   line-aligned address (offset bits zero)
//  mem_req_ack    in   1        request accepted
//  mem_rsp_val    in   1        refill data valid (single beat)
//  mem_rsp_data   in   LINE_W   refill data
//  fill_en        out  1        write tag+valid+data
//  fill_idx       out  IDX_W    fill set
//  fill_way       out  WAY_NUM  fill way
//  fill_tag       out  TAG_W    fill tag
//  fill_data      out  LINE_W   registered mem_rsp_data
//  replay         out  1        one-cycle pulse: core re-issues the miss
//  flush_done     out  1        one-cycle pulse at end of sweep
//  timeout_err    out  1        one-cycle pulse per WAIT timeout
// BEHAVIOUR
//  - Reset: state=IDLE; all out pulses/enables 0; registers 0; stall=1 while ~arr_ready.
//  - stall = ~arr_ready | miss_val | (state!=IDLE); combinational, so miss stalls same cycle.
//  - FSM states: IDLE, INV, REQ, WAIT, FILL, REPLAY, FLUSH.
//  - IDLE & arr_ready & miss_val: capture addr, way, evict_val.
//    Next state is INV if evict_val, else REQ.
//  - miss_val has priority over flush_req in the same cycle; flush_req is re-sampled on return to IDLE.
//  - INV: inv_en=1 for exactly 1 cycle, inv_idx=addr idx, inv_way=victim -> REQ.
//  - REQ: mem_req_val=1, addr stable until mem_req_ack; ack -> WAIT.
//    mem_req_val is held, never dropped before ack.
//  - WAIT: count cycles. mem_rsp_val -> latch data, go FILL.
//    At count==TIMEOUT_CYC without rsp: timeout_err pulse, counter clears, go REQ (reissue).
//    rsp on the same cycle as expiry wins (no error).
//  - FILL: fill_en=1 for 1 cycle with captured idx/way/tag/data -> REPLAY.
//  - REPLAY: replay=1 for 1 cycle, stall=1 -> IDLE (stall drops next cycle).
//  - FLUSH: idx counter from 0; inv_en=1 each cycle, inv_way=all ones.
//    At idx=2**IDX_W-1: flush_done pulse -> IDLE; 2**IDX_W cycles total. Counter wraps to 0.
//  - mem_rsp_val outside WAIT is ignored. miss_val outside IDLE is ignored (core already stalled).
//  - rst mid-operation: immediate return to IDLE next edge; an outstanding bus request is abandoned.
//    The bus is reset on the same rst.
//  - victim_way not one-hot is an assertion error; no recovery logic.
// STRUCTURE
//  - Shared package/defines: CORE_IDX_WIDTH, L1_WAY_NUM, line/tag widths, FSM state encoding.
//  - Single module. No sub-module: FSM, timeout counter, flush counter and capture regs are inline.
// TESTING
//  1. Hold arr_ready=0 10 cycles with miss_val=1 -> stall=1, no inv/mem activity;
//     raise arr_ready -> miss accepted.
//  2. miss 0x0000_1230, evict_val=0, way=4'b0100, ack after 2, rsp after 3, data=X
//     -> mem_req_addr=0x1230; fill idx=0x23, way=0100, data=X; replay pulse; stall low after REPLAY.
//  3. Same with evict_val=1 -> inv_en single cycle idx=0x23 way=0100, before first mem_req_val.
//  4. No rsp for 255 WAIT cycles -> timeout_err pulse, mem_req_val reasserted same addr;
//     rsp on retry completes fill.
//  5. flush_req and miss_val same cycle -> miss completes first, then FLUSH 128 cycles inv_way=1111,
//     flush_done once.
//  6. rst asserted in WAIT -> next cycle IDLE, outputs 0; later rsp ignored; new miss handled normally.

Source files
------------

// File: rtl/l1_miss_ctrl_pkg.sv
// Shared widths and FSM encoding for the L1 miss/refill sequencer.
// Module parameters default to these values so the core config is defined in one place.
package l1_miss_ctrl_pkg;

  localparam int L1_ADDR_W      = 32;
  localparam int CORE_IDX_WIDTH = 7;
  localparam int L1_OFF_W       = 4;
  localparam int L1_WAY_NUM     = 4;
  localparam int L1_LINE_W      = 128;
  localparam int L1_TAG_W       = L1_ADDR_W - CORE_IDX_WIDTH - L1_OFF_W;
  localparam int L1_TIMEOUT_CYC = 255;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INV    = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_FILL   = 3'd4;
  localparam logic [2:0] ST_REPLAY = 3'd5;
  localparam logic [2:0] ST_FLUSH  = 3'd6;

endpackage

// File: rtl/l1_miss_ctrl_if.sv
// Line-read memory bus between the miss sequencer (master) and the memory side (slave).
interface l1_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);

  logic              mem_req_val;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ack;
  logic              mem_rsp_val;
  logic [LINE_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_val, mem_req_addr,
    input  mem_req_ack, mem_rsp_val, mem_rsp_data
  );

  modport slave (
    input  mem_req_val, mem_req_addr,
    output mem_req_ack, mem_rsp_val, mem_rsp_data
  );

endinterface

// File: rtl/l1_miss_ctrl.sv
// L1 miss/refill sequencer: invalidate victim, fetch line, fill arrays, replay the request.
// Also sweeps every set clearing all ways when a flush is requested.
module l1_miss_ctrl
  import l1_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W      = L1_ADDR_W,
  parameter int IDX_W       = CORE_IDX_WIDTH,
  parameter int OFF_W       = L1_OFF_W,
  parameter int WAY_NUM     = L1_WAY_NUM,
  parameter int LINE_W      = L1_LINE_W,
  parameter int TIMEOUT_CYC = L1_TIMEOUT_CYC
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arr_ready,
  input  logic                            miss_val,
  input  logic [ADDR_W-1:0]               miss_addr,
  input  logic                            evict_val,
  input  logic [WAY_NUM-1:0]              victim_way,
  input  logic                            flush_req,
  output logic                            stall,
  output logic                            inv_en,
  output logic [IDX_W-1:0]                inv_idx,
  output logic [WAY_NUM-1:0]              inv_way,
  l1_miss_ctrl_if.master                  mem,
  output logic                            fill_en,
  output logic [IDX_W-1:0]                fill_idx,
  output logic [WAY_NUM-1:0]              fill_way,
  output logic [ADDR_W-IDX_W-OFF_W-1:0]   fill_tag,
  output logic [LINE_W-1:0]               fill_data,
  output logic                            replay,
  output logic                            flush_done,
  output logic                            timeout_err
);

  localparam int               TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = '1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W)'((1 << OFF_W) - 1));

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [WAY_NUM-1:0] way_reg;
  logic [LINE_W-1:0] data_reg;
  logic [7:0]        wait_cnt_reg;
  logic [IDX_W-1:0]  flush_cnt_reg;
  logic              accept;
  logic              wait_expire;

  assign accept      = (state_reg == ST_IDLE) & arr_ready & miss_val;
  // A response arriving on the expiry cycle wins over the timeout.
  assign wait_expire = (state_reg == ST_WAIT) & ~mem.mem_rsp_val & (wait_cnt_reg == TIMEOUT_V);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arr_ready) begin
          if (miss_val)       state_next = evict_val ? ST_INV : ST_REQ;
          else if (flush_req) state_next = ST_FLUSH;
        end
      end
      ST_INV:    state_next = ST_REQ;
      ST_REQ:    if (mem.mem_req_ack) state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem.mem_rsp_val) state_next = ST_FILL;
        else if (wait_expire) state_next = ST_REQ;
      end
      ST_FILL:   state_next = ST_REPLAY;
      ST_REPLAY: state_next = ST_IDLE;
      ST_FLUSH:  if (flush_cnt_reg == IDX_LAST) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      way_reg       <= '0;
      data_reg      <= '0;
      wait_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= miss_addr & LINE_MASK;
        way_reg  <= victim_way;
      end
      if ((state_reg == ST_WAIT) && !mem.mem_rsp_val && !wait_expire)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      else
        wait_cnt_reg <= '0;
      if ((state_reg == ST_WAIT) && mem.mem_rsp_val)
        data_reg <= mem.mem_rsp_data;
      // Free-running during the sweep so it lands back on 0 at the last set.
      if (state_reg == ST_FLUSH)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall            = ~arr_ready | miss_val | (state_reg != ST_IDLE);
  assign inv_en           = (state_reg == ST_INV) | (state_reg == ST_FLUSH);
  assign inv_idx          = (state_reg == ST_FLUSH) ? flush_cnt_reg : addr_reg[OFF_W +: IDX_W];
  assign inv_way          = (state_reg == ST_FLUSH) ? {WAY_NUM{1'b1}} : way_reg;
  assign mem.mem_req_val  = (state_reg == ST_REQ);
  assign mem.mem_req_addr = addr_reg;
  assign fill_en          = (state_reg == ST_FILL);
  assign fill_idx         = addr_reg[OFF_W +: IDX_W];
  assign fill_way         = way_reg;
  assign fill_tag         = addr_reg[ADDR_W-1 -: TAG_W];
  assign fill_data        = data_reg;
  assign replay           = (state_reg == ST_REPLAY);
  assign flush_done       = (state_reg == ST_FLUSH) & (flush_cnt_reg == IDX_LAST);
  assign timeout_err      = wait_expire;

  a_victim_onehot: assert property (@(posedge clk) disable iff (rst) accept |-> $onehot(victim_way));

endmodule
